// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the convolution scan controller.
package conv_pkg;

    localparam int KX   = 3;
    localparam int KY   = 3;
    localparam int OX   = 19;
    localparam int OY   = 19;
    localparam int KPOS = 9;

    localparam int KW = 2;  // kernel counter width
    localparam int OW = 5;  // output counter width
    localparam int AW = 4;  // weight address width

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/count_wrap.sv
// Wrapping up-counter 0..MAX with enable and carry-out, async active-low reset.
module count_wrap #(
    parameter int W   = 2,
    parameter int MAX = 2
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         co
);

    localparam logic [W-1:0] MAXV = W'(MAX);

    assign co = en && (q == MAXV);

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            q <= '0;
        end else if (en) begin
            q <= (q == MAXV) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/conv_scan_ctrl.sv
// Convolution scan controller: weight load then x/y/X/Y nested scan.
// Optional stall support selected by macro CONV_SCAN_STALL_EN.
module conv_scan_ctrl
    import conv_pkg::*;
(
    input  logic          clk,
    input  logic          xrst,
    input  logic          start,
`ifdef CONV_SCAN_STALL_EN
    input  logic          stall,
`endif
    output logic          busy,
    output logic          finish,
    output logic [AW-1:0] w_raddr,
    output logic          w_load,
    output logic [AW-1:0] w_load_idx,
    output logic [KW-1:0] x,
    output logic [KW-1:0] y,
    output logic [OW-1:0] X,
    output logic [OW-1:0] Y,
    output logic          step_x,
    output logic          step_y,
    output logic          step_X,
    output logic          ret
);

    localparam logic [KW-1:0] X_MAX  = KW'(KX - 1);
    localparam logic [KW-1:0] Y_MAX  = KW'(KY - 1);
    localparam logic [OW-1:0] OX_MAX = OW'(OX - 1);
    localparam logic [AW-1:0] K_LAST = AW'(KPOS - 1);

    state_t        state, nxt;
    logic [AW-1:0] kcnt;
    logic          stl;
    logic          run_en;
    logic          x_co, y_co, X_co, Y_co;

`ifdef CONV_SCAN_STALL_EN
    assign stl = stall;
`else
    assign stl = 1'b0;
`endif

    assign run_en = (state == S_RUN) && !stl;

    // Counters idle at 0 outside RUN because a full pass always wraps them back.
    count_wrap #(.W(KW), .MAX(KX - 1)) u_x (.clk(clk), .xrst(xrst), .en(run_en), .q(x), .co(x_co));
    count_wrap #(.W(KW), .MAX(KY - 1)) u_y (.clk(clk), .xrst(xrst), .en(x_co),   .q(y), .co(y_co));
    count_wrap #(.W(OW), .MAX(OX - 1)) u_X (.clk(clk), .xrst(xrst), .en(y_co),   .q(X), .co(X_co));
    count_wrap #(.W(OW), .MAX(OY - 1)) u_Y (.clk(clk), .xrst(xrst), .en(X_co),   .q(Y), .co(Y_co));

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            kcnt       <= '0;
            w_load     <= 1'b0;
            w_load_idx <= '0;
        end else begin
            if (state == S_LOAD && kcnt != K_LAST) begin
                kcnt <= kcnt + 1'b1;
            end else begin
                kcnt <= '0;
            end
            // Weight memory has one cycle of read latency.
            w_load     <= (state == S_LOAD);
            w_load_idx <= w_raddr;
        end
    end

    always_comb begin
        nxt     = state;
        busy    = (state != S_IDLE);
        finish  = 1'b0;
        w_raddr = '0;
        step_x  = 1'b0;
        step_y  = 1'b0;
        step_X  = 1'b0;
        ret     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) nxt = S_LOAD;
            end
            S_LOAD: begin
                w_raddr = kcnt;
                if (kcnt == K_LAST) nxt = S_RUN;
            end
            S_RUN: begin
                if (run_en) begin
                    step_x = (x != X_MAX);
                    step_y = (x == X_MAX) && (y != Y_MAX);
                    step_X = (x == X_MAX) && (y == Y_MAX) && (X != OX_MAX);
                    ret    = (x == X_MAX) && (y == Y_MAX) && (X == OX_MAX);
                end
                if (Y_co) nxt = S_DONE;
            end
            S_DONE: begin
                finish = 1'b1;
                nxt    = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl against a position-index model.
module tb_conv_scan_ctrl;

    localparam int NPOS = 3249;

    logic       clk = 1'b0;
    logic       xrst, start, stall;
    logic       busy, finish, w_load;
    logic [3:0] w_raddr, w_load_idx;
    logic [1:0] x, y;
    logic [4:0] X, Y;
    logic       step_x, step_y, step_X, ret;

    always #5 clk = ~clk;

    conv_scan_ctrl dut (
        .clk(clk), .xrst(xrst), .start(start),
`ifdef CONV_SCAN_STALL_EN
        .stall(stall),
`endif
        .busy(busy), .finish(finish),
        .w_raddr(w_raddr), .w_load(w_load), .w_load_idx(w_load_idx),
        .x(x), .y(y), .X(X), .Y(Y),
        .step_x(step_x), .step_y(step_y), .step_X(step_X), .ret(ret)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 load (index l), 2 run (flat position r), 3 done
    int mode = 0, l = 0, r = 0, cyc = 0, k0 = 0, stall_run = 0;
    int pl = 0, praddr = 0;
    int fin_cnt = 0, fin_rel = 0;
    int sx = 0, sy = 0, sX = 0, sr = 0;

    function automatic bit stall_eff();
`ifdef CONV_SCAN_STALL_EN
        return stall;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        int rel, n;
        bit run, adv;
        if (!xrst) begin
            mode = 0; l = 0; r = 0; pl = 0; praddr = 0;
        end
        rel = cyc - k0 + 1;
        run = (mode == 2);
        adv = run && !stall_eff();
        n   = r + 1;
        chk("busy",   busy,   (mode != 0));
        chk("finish", finish, (mode == 3));
        chk("w_raddr",    w_raddr,    (mode == 1) ? l : 0);
        chk("w_load",     w_load,     pl);
        chk("w_load_idx", w_load_idx, praddr);
        chk("x", x, run ? r % 3 : 0);
        chk("y", y, run ? (r / 3) % 3 : 0);
        chk("X", X, run ? (r / 9) % 19 : 0);
        chk("Y", Y, run ? r / 171 : 0);
        chk("step_x", step_x, adv && (n % 3 != 0));
        chk("step_y", step_y, adv && (n % 3 == 0) && (n % 9 != 0));
        chk("step_X", step_X, adv && (n % 9 == 0) && (n % 171 != 0));
        chk("ret",    ret,    adv && (n % 171 == 0));
        if (adv && r == 683) chk("ret_at_Y3", ret, 1);
        if (run && r == 684) begin
            chk("wrap_x", x, 0); chk("wrap_y", y, 0);
            chk("wrap_X", X, 0); chk("wrap_Y", Y, 4);
        end
        if (xrst) begin
            sx += int'(step_x); sy += int'(step_y); sX += int'(step_X); sr += int'(ret);
            if (finish === 1'b1) begin
                fin_cnt++;
                fin_rel = rel;
            end
            cyc++;
            pl = (mode == 1);
            praddr = (mode == 1) ? l : 0;
            case (mode)
                0: if (start) begin mode = 1; l = 0; k0 = cyc; stall_run = 0; end
                1: if (l == 8) begin mode = 2; r = 0; end else l++;
                2: if (stall_eff()) stall_run++;
                   else if (r == NPOS - 1) mode = 3;
                   else r++;
                default: mode = 0;
            endcase
        end
    end

    task automatic clear_counts();
        sx = 0; sy = 0; sX = 0; sr = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_finish(input int f0);
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (fin_cnt != f0) break;
        end
        chk("finish_seen", fin_cnt, f0 + 1);
    endtask

    initial begin
        int f0;
        xrst = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_finish", finish, 0);
        chk("rst_w_load", w_load, 0);
        chk("rst_steps", {step_x, step_y, step_X, ret}, 0);

        // Pass 1: start on the first edge after release, stray start at cycle 500
        @(posedge clk); #2 xrst = 1'b1; start = 1'b1;
        clear_counts();
        f0 = fin_cnt;
        @(posedge clk); #2 start = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk); #1;
            if (i == 1)  chk("raddr_c1", w_raddr, 0);
            if (i == 9)  chk("raddr_c9", w_raddr, 8);
            if (i == 1)  chk("wload_c1", w_load, 0);
            if (i == 2)  chk("wload_c2", {w_load, w_load_idx}, {1'b1, 4'd0});
            if (i == 10) chk("wload_c10", {w_load, w_load_idx}, {1'b1, 4'd8});
            if (i == 11) chk("wload_c11", w_load, 0);
        end
        repeat (489) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_finish(f0);
        chk("finish_cycle", fin_rel, 3259);
        chk("cnt_step_x", sx, 2166); chk("cnt_step_y", sy, 722);
        chk("cnt_step_X", sX, 342);  chk("cnt_ret", sr, 19);
        @(negedge clk); #1 chk("busy_3260", busy, 0);

        // Pass 2: asynchronous reset at cycle 1000 abandons the pass
        f0 = fin_cnt;
        pulse_start();
        repeat (998) @(posedge clk);
        #2 xrst = 1'b0;
        #1;
        chk("arst_busy", busy, 0); chk("arst_finish", finish, 0);
        chk("arst_cnt", {x, y, X, Y}, 0);
        chk("arst_w", {w_raddr, w_load, w_load_idx}, 0);
        chk("arst_steps", {step_x, step_y, step_X, ret}, 0);
        repeat (3) @(posedge clk);
        #2 xrst = 1'b1;
        repeat (3) @(posedge clk);
        chk("arst_no_finish", fin_cnt, f0);
        chk("arst_idle", busy, 0);
        pulse_start();
        wait_finish(f0);
        chk("finish_after_rst", fin_rel, 3259);

`ifdef CONV_SCAN_STALL_EN
        // Pass 3: five stalled cycles at X=7
        f0 = fin_cnt;
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (mode == 2 && r == 62) break;
        end
        @(posedge clk); #2 stall = 1'b1;
        repeat (5) @(posedge clk);
        #2 stall = 1'b0;
        wait_finish(f0);
        chk("finish_stall5", fin_rel, 3264);
`endif

        // Pass 4: random start noise (and random stalls when supported)
        f0 = fin_cnt;
        @(posedge clk); #2 start = 1'b1;
        for (int i = 0; i < 12000; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 7) == 0);
`ifdef CONV_SCAN_STALL_EN
            stall = ($urandom_range(0, 3) == 0);
`endif
            if (fin_cnt != f0) break;
        end
        start = 1'b0; stall = 1'b0;
        chk("rand_finish_seen", fin_cnt, f0 + 1);
        chk("rand_finish_cycle", fin_rel, 3259 + stall_run);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_scan_ctrl.md
CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; xrst  in  1  reset (asynchronous, active-low).
REQ-002 SHALL have ports: start  in  1  one-cycle request to begin one full convolution pass; stall  in  1  freeze scan (present only with macro, REQ-025).
REQ-003 SHALL have ports: busy  out  1  pass in progress; finish  out  1  one-cycle end-of-pass pulse.
REQ-004 SHALL have ports: w_raddr  out  4  kernel-position read address shared by all 16 weight memories; w_load  out  1  weight capture strobe; w_load_idx  out  4  kernel position being captured.
REQ-005 SHALL have ports: x  out  2  kernel column 0..2; y  out  2  kernel row 0..2; X  out  5  output column 0..18; Y  out  5  output row 0..18.
REQ-006 SHALL have ports: step_x, step_y, step_X, ret  out  1 each  weight-shift commands to the weight register array.

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, RUN, DONE; reset state IDLE.
REQ-008 IDLE->LOAD when start=1; start in any other state ignored.
REQ-009 LOAD: exactly 9 cycles; w_raddr = 0,1,...,8 on consecutive cycles; then ->RUN.
REQ-010 Memory read latency 1 cycle: w_load=1 and w_load_idx = w_raddr of previous cycle, i.e. w_load high for 9 cycles starting one cycle after LOAD entry (last strobe coincides with first RUN cycle).
REQ-011 RUN: nested scan, x innermost (0..2), then y (0..2), then X (0..18), then Y (0..18); one position per unstalled cycle; 3249 cycles total.
REQ-012 Wrap rules: x 2->0 increments y; y 2->0 with x=2 increments X; X 18->0 with x=y=2 increments Y.
REQ-013 Shift commands, combinational decode of registered counters in RUN, asserted in the cycle before the advance: step_x when x<2; step_y when x=2,y<2; step_X when x=2,y=2,X<18; ret when x=2,y=2,X=18.
REQ-014 Exactly one of step_x/step_y/step_X/ret is high in each unstalled RUN cycle; all low outside RUN.
REQ-015 Final position (x=2,y=2,X=18,Y=18): ret asserted, next state DONE, counters return to 0.
REQ-016 DONE: one cycle, finish=1, then ->IDLE.
REQ-017 busy=1 in LOAD, RUN, DONE; 0 in IDLE.
REQ-018 From start sampled at cycle 0: LOAD cycles 1..9, RUN cycles 10..3258, finish=1 at cycle 3259 (no stall).
REQ-019 x, y, X, Y, w_raddr SHALL read 0 whenever not in RUN/LOAD respectively.

Reset
REQ-020 xrst=0 SHALL asynchronously force state IDLE and all counters, w_raddr, w_load_idx to 0.
REQ-021 During reset: busy, finish, w_load, step_x, step_y, step_X, ret all 0.
REQ-022 Reset asserted mid-LOAD or mid-RUN SHALL abandon the pass with no finish pulse; a new start is required after release.
REQ-023 First start is accepted on the first rising edge after xrst deasserts.

Configuration
REQ-024 Macro CONV_SCAN_STALL_EN SHALL select stall support.
REQ-025 With CONV_SCAN_STALL_EN: stall port present; stall=1 in RUN freezes x,y,X,Y, forces all step/ret low, delays finish one cycle per stalled cycle; stall ignored in IDLE/LOAD/DONE.
REQ-026 Without CONV_SCAN_STALL_EN: no stall port; RUN advances every cycle.

Structure
REQ-027 Shared package conv_pkg SHALL hold KX=3, KY=3, OX=19, OY=19, KPOS=9, counter widths and the FSM state enum.
REQ-028 Sub-module count_wrap (parameterized max, enable, carry out, async xrst) SHALL be instantiated four times for x, y, X, Y, chained through carry.

Verification
REQ-029 Reset, start at cycle 0 -> w_raddr 0..8 at cycles 1..9; w_load=1 with w_load_idx 0..8 at cycles 2..10.
REQ-030 Full pass, no stall -> finish=1 exactly at cycle 3259, busy low at 3260; step_x count 2166, step_y 722, step_X 342, ret 19.
REQ-031 At x=2,y=2,X=18,Y=3 -> ret=1; next cycle x=y=X=0, Y=4.
REQ-032 start pulsed at cycle 500 during RUN -> ignored, finish still at 3259.
REQ-033 xrst low at cycle 1000 -> all outputs 0 immediately, IDLE, no finish; new start gives finish 3259 cycles later.
REQ-034 (CONV_SCAN_STALL_EN) stall=1 for 5 cycles at X=7 -> counters frozen, steps low, finish at cycle 3264.
